bfm_apb_bridge_arbiter: RTL and testbench
=========================================

Name: bfm_apb_bridge_arbiter

Overview:
- Four-requester APB master arbiter for the BFM APB-to-APB bridge master port (PM side).
- Serialises requester transfers onto one PADDR/PWRITE/PENABLE/PWDATA bus.
- Each transfer starts on a fresh PENABLE rising edge, which is what the bridge needs.
- Returns read data and slave error to the granted requester, with a per-transfer ACK pulse and a sticky watchdog timeout flag.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (requester 0 highest).
- TIMEOUT, 256, ACCESS-phase cycle limit before TIMEOUT_ERR sets; 0 disables the watchdog. Width 16 bits.

Ports:
- PCLK_PM  in  1  clock.
- PRESETN_PM  in  1  asynchronous active-low reset.
- REQ  in  4  per-requester transfer request; level, held until ACK.
- ADDR_IN  in  128  requester i address at [32i+31:32i].
- WRITE_IN  in  4  1 = write, 0 = read, per requester.
- WDATA_IN  in  128  requester i write data at [32i+31:32i].
- GNT  out  4  one-hot, requester currently owning the bus.
- ACK  out  4  one-cycle completion pulse to the granted requester.
- RDATA_OUT  out  32  read data of the last completed transfer.
- SLVERR_OUT  out  1  PSLVERR of the last completed transfer.
- BUSY  out  1  high in any state other than IDLE.
- TIMEOUT_ERR  out  1  sticky watchdog flag.
- CLR_TIMEOUT  in  1  synchronous clear of TIMEOUT_ERR.
- PADDR_PM  out  32  to bridge.
- PWRITE_PM  out  1  to bridge.
- PENABLE_PM  out  1  to bridge.
- PWDATA_PM  out  32  to bridge.
- PRDATA_PM  in  32  from bridge.
- PREADY_PM  in  1  from bridge; single-cycle pulse.
- PSLVERR_PM  in  1  from bridge.

Behaviour:
- Clock and reset: PCLK_PM clock; reset PRESETN_PM, asynchronous, active-low.
- Reset values:
  - All outputs 0; state IDLE; round-robin pointer = 3, so requester 0 is searched first; watchdog counter 0.
- IDLE:
  - If REQ != 0, pick a winner and go to SETUP.
  - On entry to SETUP: GNT = one-hot(winner); PADDR_PM, PWRITE_PM, PWDATA_PM latched from the winner's slice; PENABLE_PM = 0.
  - With no request, stay in IDLE with GNT = 0.
- SETUP (1 cycle):
  - Go to ACCESS, PENABLE_PM <= 1, watchdog counter cleared.
- ACCESS:
  - Hold address, control and data stable.
  - On a sampled PREADY_PM = 1: go to DONE, PENABLE_PM <= 0, RDATA_OUT <= PRDATA_PM, SLVERR_OUT <= PSLVERR_PM, ACK[winner] <= 1.
  - Otherwise increment the watchdog counter, saturating.
  - When the counter reaches TIMEOUT (TIMEOUT != 0), set TIMEOUT_ERR. Keep waiting; never abort.
- DONE (1 cycle):
  - ACK <= 0, GNT <= 0.
  - PADDR_PM, PWRITE_PM, PWDATA_PM <= 0.
  - Go to IDLE.
  - PENABLE_PM is therefore low for at least 2 cycles between transfers.
- Timing:
  - Minimum cost per transfer is 4 PCLK_PM cycles plus the bridge latency.
  - REQ is sampled only in IDLE, so a requester that drops REQ on the ACK edge is not re-granted.
- Arbitration:
  - ARB_MODE 0: search from pointer+1 modulo 4; pointer <= winner on grant.
  - ARB_MODE 1: lowest asserted index wins; pointer unused.
- Requester inputs are don't-care after grant (values are latched). Deasserting REQ mid-transfer does not cancel it; ACK still pulses.
- PREADY_PM is ignored outside ACCESS.
- TIMEOUT_ERR:
  - Set has priority over CLR_TIMEOUT in the same cycle.
  - Cleared only by CLR_TIMEOUT or reset.
- RDATA_OUT and SLVERR_OUT hold until the next completion; writes update them too, with whatever the bridge returns.
- Reset mid-transfer: immediate return to reset values. The bridge shares PRESETN_PM, so no recovery is needed.

Test Plan:
- Single read: REQ=0001, ADDR_IN[31:0]=0x0300_0010, bridge returns PRDATA=0xA5A5_1234 with PREADY at ACCESS cycle 3 -> PADDR_PM=0x0300_0010, PWRITE_PM=0, PENABLE_PM high for exactly 3 cycles, ACK=0001 for one cycle, RDATA_OUT=0xA5A5_1234, SLVERR_OUT=0.
- Round-robin fairness: REQ=1111 held, each requester dropping its REQ one cycle after its ACK and re-raising it 2 cycles later -> grant order 0,1,2,3,0,1; PENABLE_PM low ≥2 cycles between transfers.
- Fixed priority (ARB_MODE=1): REQ=1010 held continuously -> requester 1 served on every grant; requester 3 starved; no ACK to 3.
- Write with error: requester 2 writes 0xDEAD_BEEF to 0x0F00_0004, bridge returns PSLVERR=1 -> PWDATA_PM=0xDEAD_BEEF, PWRITE_PM=1, ACK=0100, SLVERR_OUT=1.
- Watchdog: TIMEOUT=8, PREADY withheld for 20 cycles -> TIMEOUT_ERR rises after 8 ACCESS cycles, transfer completes at cycle 20 with ACK pulse, TIMEOUT_ERR stays 1 until CLR_TIMEOUT pulse; CLR_TIMEOUT in the same cycle as the set leaves the flag 1.
- Reset mid-ACCESS: assert PRESETN_PM=0 during ACCESS -> PENABLE_PM, GNT, ACK, BUSY go to 0 asynchronously; after release, REQ=0001 is served normally starting from requester 0.

Source files
------------

// File: rtl/bfm_apb_bridge_arbiter.sv
// bfm_apb_bridge_arbiter: four-requester APB master arbiter for the bridge PM port
// Ports:
//   PCLK_PM, PRESETN_PM         clock, asynchronous active-low reset
//   REQ/ADDR_IN/WRITE_IN/WDATA_IN  per-requester transfer requests (32-bit slices)
//   GNT, ACK                    one-hot grant and one-cycle completion pulse
//   RDATA_OUT, SLVERR_OUT       response of the last completed transfer
//   BUSY, TIMEOUT_ERR, CLR_TIMEOUT  status, sticky watchdog flag and its clear
//   P*_PM                       APB master bus toward the bridge
module bfm_apb_bridge_arbiter #(
  parameter int          ARB_MODE = 0,
  parameter logic [15:0] TIMEOUT  = 16'd256
) (
  input  logic         PCLK_PM,
  input  logic         PRESETN_PM,
  input  logic [3:0]   REQ,
  input  logic [127:0] ADDR_IN,
  input  logic [3:0]   WRITE_IN,
  input  logic [127:0] WDATA_IN,
  output logic [3:0]   GNT,
  output logic [3:0]   ACK,
  output logic [31:0]  RDATA_OUT,
  output logic         SLVERR_OUT,
  output logic         BUSY,
  output logic         TIMEOUT_ERR,
  input  logic         CLR_TIMEOUT,
  output logic [31:0]  PADDR_PM,
  output logic         PWRITE_PM,
  output logic         PENABLE_PM,
  output logic [31:0]  PWDATA_PM,
  input  logic [31:0]  PRDATA_PM,
  input  logic         PREADY_PM,
  input  logic         PSLVERR_PM
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t      state, state_nx;
  logic [1:0]  ptr, win, idx;
  logic        found, to_set;
  logic [15:0] wd_cnt;
  // Fixed priority scans 0..3; round-robin scans ptr+1..ptr+4 with 2-bit wrap.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = (ARB_MODE == 1) ? 2'(k - 1) : ptr + 2'(k);
      if (!found && REQ[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE   ? (|REQ ? SETUP : IDLE) :
               state == SETUP  ? ACCESS :
               state == ACCESS ? (PREADY_PM ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM)
    if (!PRESETN_PM) state <= IDLE;
    else state <= state_nx;
  assign BUSY = state != IDLE;
  // Fires once, on the wait cycle that brings the counter up to TIMEOUT.
  assign to_set = state == ACCESS && !PREADY_PM && TIMEOUT != 16'd0 && wd_cnt + 16'd1 == TIMEOUT;
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM)
    if (!PRESETN_PM) begin
      GNT <= '0;
      ACK <= '0;
      RDATA_OUT <= '0;
      SLVERR_OUT <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      PADDR_PM <= '0;
      PWRITE_PM <= 1'b0;
      PENABLE_PM <= 1'b0;
      PWDATA_PM <= '0;
      ptr <= 2'd3;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|REQ) begin
          GNT <= 4'b0001 << win;
          PADDR_PM <= ADDR_IN[32*win +: 32];
          PWRITE_PM <= WRITE_IN[win];
          PWDATA_PM <= WDATA_IN[32*win +: 32];
          PENABLE_PM <= 1'b0;
          if (ARB_MODE == 0) ptr <= win;
        end
        SETUP: begin
          PENABLE_PM <= 1'b1;
          wd_cnt <= '0;
        end
        ACCESS: if (PREADY_PM) begin
          PENABLE_PM <= 1'b0;
          RDATA_OUT <= PRDATA_PM;
          SLVERR_OUT <= PSLVERR_PM;
          ACK <= GNT;
        end else if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
        default: begin
          ACK <= '0;
          GNT <= '0;
          PADDR_PM <= '0;
          PWRITE_PM <= 1'b0;
          PWDATA_PM <= '0;
        end
      endcase
      TIMEOUT_ERR <= to_set | (TIMEOUT_ERR & ~CLR_TIMEOUT);
    end
endmodule

// File: tb/tb_bfm_apb_bridge_arbiter.sv
// tb_bfm_apb_bridge_arbiter: table-driven and directed checks of the APB arbiter
module tb_bfm_apb_bridge_arbiter;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  localparam logic [127:0] ADDRS = {32'h3333_0003, 32'h0F00_0004, 32'h1111_0001, 32'h0300_0010};
  localparam logic [127:0] WDATS = {32'hC0DE_0003, 32'hDEAD_BEEF, 32'hC0DE_0001, 32'hC0DE_0000};
  logic [3:0]  req_a = '0, wr_a = '0, gnt_a, ack_a, req_b = '0, gnt_b, ack_b;
  logic [31:0] prdata_a = '0, rdata_a, paddr_a, pwdata_a, rdata_b, paddr_b, pwdata_b;
  logic        perr_a = 0, pready_a = 0, clr_a = 0, pready_b = 0;
  logic        slverr_a, busy_a, to_a, pwrite_a, penable_a;
  logic        slverr_b, busy_b, to_b, pwrite_b, penable_b;
  int tests = 0, fails = 0, vi = 0;
  bfm_apb_bridge_arbiter #(.ARB_MODE(0), .TIMEOUT(16'd8)) dut_a (
    .PCLK_PM(clk), .PRESETN_PM(rstn), .REQ(req_a), .ADDR_IN(ADDRS), .WRITE_IN(wr_a),
    .WDATA_IN(WDATS), .GNT(gnt_a), .ACK(ack_a), .RDATA_OUT(rdata_a), .SLVERR_OUT(slverr_a),
    .BUSY(busy_a), .TIMEOUT_ERR(to_a), .CLR_TIMEOUT(clr_a), .PADDR_PM(paddr_a),
    .PWRITE_PM(pwrite_a), .PENABLE_PM(penable_a), .PWDATA_PM(pwdata_a),
    .PRDATA_PM(prdata_a), .PREADY_PM(pready_a), .PSLVERR_PM(perr_a));
  bfm_apb_bridge_arbiter #(.ARB_MODE(1), .TIMEOUT(16'd0)) dut_b (
    .PCLK_PM(clk), .PRESETN_PM(rstn), .REQ(req_b), .ADDR_IN(ADDRS), .WRITE_IN(4'b0000),
    .WDATA_IN(WDATS), .GNT(gnt_b), .ACK(ack_b), .RDATA_OUT(rdata_b), .SLVERR_OUT(slverr_b),
    .BUSY(busy_b), .TIMEOUT_ERR(to_b), .CLR_TIMEOUT(1'b0), .PADDR_PM(paddr_b),
    .PWRITE_PM(pwrite_b), .PENABLE_PM(penable_b), .PWDATA_PM(pwdata_b),
    .PRDATA_PM(32'h0000_00B0), .PREADY_PM(pready_b), .PSLVERR_PM(1'b0));
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  wr;
    int          lat;
    logic [31:0] prdata;
    logic        perr;
    logic [3:0]  gnt;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, vi, act, exp);
    end
  endtask
  // One full transfer on instance A starting from an IDLE negedge.
  task automatic apply(input vec_t v);
    int pen;
    if (v.rst) begin
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
    end
    req_a = v.req;
    wr_a = v.wr;
    prdata_a = v.prdata;
    perr_a = v.perr;
    @(negedge clk);
    chk("setup_gnt", gnt_a, v.gnt);
    chk("setup_paddr", paddr_a, v.paddr);
    chk("setup_pwrite", pwrite_a, v.pwrite);
    chk("setup_pwdata", pwdata_a, v.pwdata);
    chk("setup_penable", penable_a, 0);
    chk("setup_busy", busy_a, 1);
    req_a = '0;
    wr_a = ~v.wr;
    @(negedge clk);
    pen = 0;
    for (int c = 1; c <= v.lat; c++) begin
      pready_a = (c == v.lat);
      pen += int'(penable_a);
      if (c == 1) chk("access_pwrite_hold", pwrite_a, v.pwrite);
      @(negedge clk);
    end
    pready_a = 1'b0;
    chk("penable_cycles", pen, v.lat);
    chk("done_ack", ack_a, v.gnt);
    chk("done_rdata", rdata_a, v.prdata);
    chk("done_slverr", slverr_a, v.perr);
    chk("done_penable", penable_a, 0);
    @(negedge clk);
    chk("idle_ack", ack_a, 0);
    chk("idle_gnt", gnt_a, 0);
    chk("idle_paddr", paddr_a, 0);
    chk("idle_penable", penable_a, 0);
    chk("idle_busy", busy_a, 0);
  endtask
  initial begin
    vec_t r;
    vecs[0]  = '{1'b0, 4'b0001, 4'b0000, 3, 32'hA5A5_1234, 1'b0, 4'b0001, 32'h0300_0010, 1'b0, 32'hC0DE_0000};
    vecs[1]  = '{1'b0, 4'b0100, 4'b0100, 1, 32'h0000_0000, 1'b1, 4'b0100, 32'h0F00_0004, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 4'b1111, 4'b1000, 2, 32'h1234_5678, 1'b0, 4'b1000, 32'h3333_0003, 1'b1, 32'hC0DE_0003};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1000, 1, 32'h0BAD_F00D, 1'b0, 4'b0001, 32'h0300_0010, 1'b0, 32'hC0DE_0000};
    vecs[4]  = '{1'b0, 4'b1010, 4'b0010, 2, 32'hCAFE_0001, 1'b1, 4'b0010, 32'h1111_0001, 1'b1, 32'hC0DE_0001};
    vecs[5]  = '{1'b0, 4'b1001, 4'b0000, 1, 32'h55AA_55AA, 1'b0, 4'b1000, 32'h3333_0003, 1'b0, 32'hC0DE_0003};
    vecs[6]  = '{1'b1, 4'b1111, 4'b0000, 1, 32'h0000_0006, 1'b0, 4'b0001, 32'h0300_0010, 1'b0, 32'hC0DE_0000};
    vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 1, 32'h0000_0007, 1'b0, 4'b0010, 32'h1111_0001, 1'b0, 32'hC0DE_0001};
    vecs[8]  = '{1'b0, 4'b1111, 4'b0000, 2, 32'h0000_0008, 1'b1, 4'b0100, 32'h0F00_0004, 1'b0, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b0, 4'b1111, 4'b0000, 1, 32'h0000_0009, 1'b0, 4'b1000, 32'h3333_0003, 1'b0, 32'hC0DE_0003};
    vecs[10] = '{1'b0, 4'b1111, 4'b0000, 1, 32'h0000_000A, 1'b0, 4'b0001, 32'h0300_0010, 1'b0, 32'hC0DE_0000};
    vecs[11] = '{1'b0, 4'b1111, 4'b0000, 3, 32'h0000_000B, 1'b0, 4'b0010, 32'h1111_0001, 1'b0, 32'hC0DE_0001};
    #3;
    chk("rst_gnt", gnt_a, 0);
    chk("rst_ack", ack_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_slverr", slverr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_timeout", to_a, 0);
    chk("rst_paddr", paddr_a, 0);
    chk("rst_pwrite", pwrite_a, 0);
    chk("rst_penable", penable_a, 0);
    chk("rst_pwdata", pwdata_a, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      vi = i;
      apply(vecs[i]);
    end
    vi = 100;
    req_a = 4'b0001;
    wr_a = '0;
    prdata_a = 32'h7777_0020;
    perr_a = 1'b0;
    @(negedge clk);
    chk("wd_gnt", gnt_a, 4'b0001);
    req_a = '0;
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      if (c == 8) begin
        chk("wd_before_limit", to_a, 0);
        clr_a = 1'b1;
      end
      if (c == 9) begin
        clr_a = 1'b0;
        chk("wd_set_beats_clear", to_a, 1);
      end
      if (c == 15) chk("wd_penable_held", penable_a, 1);
      pready_a = (c == 20);
      @(negedge clk);
    end
    pready_a = 1'b0;
    chk("wd_ack", ack_a, 4'b0001);
    chk("wd_rdata", rdata_a, 32'h7777_0020);
    chk("wd_sticky_done", to_a, 1);
    @(negedge clk);
    chk("wd_sticky_idle", to_a, 1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("wd_cleared", to_a, 0);
    vi = 200;
    req_a = 4'b0001;
    @(negedge clk);
    req_a = '0;
    @(negedge clk);
    chk("mid_penable", penable_a, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_penable", penable_a, 0);
    chk("async_gnt", gnt_a, 0);
    chk("async_ack", ack_a, 0);
    chk("async_busy", busy_a, 0);
    chk("async_paddr", paddr_a, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    r = '{1'b0, 4'b1111, 4'b0000, 2, 32'h0000_0300, 1'b0, 4'b0001, 32'h0300_0010, 1'b0, 32'hC0DE_0000};
    apply(r);
    vi = 300;
    req_b = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fp_gnt", gnt_b, 4'b0010);
      chk("fp_paddr", paddr_b, 32'h1111_0001);
      @(negedge clk);
      pready_b = 1'b1;
      @(negedge clk);
      pready_b = 1'b0;
      chk("fp_ack", ack_b, 4'b0010);
      chk("fp_rdata", rdata_b, 32'h0000_00B0);
      @(negedge clk);
      chk("fp_idle_gnt", gnt_b, 0);
    end
    req_b = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
